// File: rtl/audio_pkg.sv
// Shared sample type, channel encoding and default timing for the I2S codec interface.
// Build option AUDIO_LOOPBACK_EN is consumed by audio_codec_i2s.
package audio_pkg;

  localparam int unsigned SAMPLE_W      = 16;
  localparam int unsigned BCLK_HALF_DEF = 4;
  localparam int unsigned SLOT_BITS_DEF = 32;
  localparam int unsigned BIT_IDX_W     = $clog2(SAMPLE_W);

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_t;

  // Serial bit for slot position pos: MSB at pos 1, zero outside 1..SAMPLE_W.
  function automatic logic slot_bit(sample_t word, int unsigned pos);
    logic bit_val;
    bit_val = 1'b0;
    if (pos >= 1 && pos <= SAMPLE_W) begin
      bit_val = word[BIT_IDX_W'(SAMPLE_W - pos)];
    end
    return bit_val;
  endfunction

endpackage

// File: rtl/audio_clk_gen.sv
// I2S timing generator: BCLK divider, frame bit counter and LR clock.
// Exports tick strobes one clk ahead of the BCLK edge they announce.
module audio_clk_gen
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_HALF  = BCLK_HALF_DEF,
  parameter int unsigned SLOT_BITS  = SLOT_BITS_DEF,
  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS,
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS),
  localparam int unsigned DIV_W      = $clog2(BCLK_HALF)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             aud_bclk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] bit_nxt,
  output channel_t         lrck
);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap      = (div_cnt == DIV_W'(BCLK_HALF - 1));
  assign rise_tick = wrap & ~aud_bclk;
  assign fall_tick = wrap &  aud_bclk;
  assign bit_nxt   = (bit_cnt == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      aud_bclk <= 1'b0;
      bit_cnt  <= CNT_W'(FRAME_BITS - 1);
      lrck     <= CH_LEFT;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
      if (wrap) begin
        aud_bclk <= ~aud_bclk;
      end
      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        lrck    <= (bit_nxt >= CNT_W'(SLOT_BITS)) ? CH_RIGHT : CH_LEFT;
      end
    end
  end

endmodule

// File: rtl/audio_codec_i2s.sv
// Codec-side I2S master: serializes effects-block samples to DACDAT, deserializes ADCDAT.
// Define AUDIO_LOOPBACK_EN to let loopback=1 feed the ADC shifter from aud_dacdat.
module audio_codec_i2s
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_HALF = BCLK_HALF_DEF,
  parameter int unsigned SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                sample_req,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_end,
  input  logic                loopback,
  output logic                aud_bclk,
  output logic                aud_daclrck,
  output logic                aud_adclrck,
  output logic                aud_dacdat,
  input  logic                aud_adcdat
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);

  logic             rise_tick;
  logic             fall_tick;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_nxt;
  channel_t         lrck;

  audio_clk_gen #(
    .BCLK_HALF (BCLK_HALF),
    .SLOT_BITS (SLOT_BITS)
  ) u_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .aud_bclk  (aud_bclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .bit_cnt   (bit_cnt),
    .bit_nxt   (bit_nxt),
    .lrck      (lrck)
  );

  assign aud_daclrck = lrck;
  assign aud_adclrck = lrck;

  // ---------------- DAC path ----------------
  sample_t          tx_hold;
  logic             primed;
  logic [CNT_W-1:0] slot_pos;

  always_comb begin
    slot_pos = bit_nxt;
    if (bit_nxt >= CNT_W'(SLOT_BITS)) begin
      slot_pos = bit_nxt - CNT_W'(SLOT_BITS);
    end
  end

  // primed holds tx_hold at zero until the first sample_req, so the first frame sends silence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_hold    <= '0;
      primed     <= 1'b0;
      aud_dacdat <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      sample_req <= fall_tick && (bit_nxt == CNT_W'(FRAME_BITS - 1));
      if (fall_tick) begin
        if (bit_nxt == '0 && primed) begin
          tx_hold <= sample_in;
        end
        if (bit_nxt == CNT_W'(FRAME_BITS - 1)) begin
          primed <= 1'b1;
        end
        aud_dacdat <= slot_bit(tx_hold, 32'(slot_pos));
      end
    end
  end

  // ---------------- ADC path ----------------
  sample_t rx_shift;
  logic    rx_bit;
  logic    rx_window;
  logic    cap_pend;

`ifdef AUDIO_LOOPBACK_EN
  assign rx_bit = loopback ? aud_dacdat : aud_adcdat;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign rx_bit          = aud_adcdat;
`endif

  assign rx_window = rise_tick && (lrck == CH_LEFT) &&
                     (bit_cnt >= CNT_W'(1)) && (bit_cnt <= CNT_W'(SAMPLE_W));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_shift   <= '0;
      cap_pend   <= 1'b0;
      sample_out <= '0;
      sample_end <= 1'b0;
    end else begin
      cap_pend   <= rx_window && (bit_cnt == CNT_W'(SAMPLE_W));
      sample_end <= cap_pend;
      if (rx_window) begin
        rx_shift <= {rx_shift[SAMPLE_W-2:0], rx_bit};
      end
      if (cap_pend) begin
        sample_out <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_audio_codec_i2s.sv
// Randomized bench for audio_codec_i2s: outputs are predicted from the clk count since reset release.
// Also pins first-request latency, request spacing, BCLK period and a few literal serial words.
module tb_audio_codec_i2s;
  import audio_pkg::*;

  localparam int H     = 4;
  localparam int SLOT  = 32;
  localparam int FRAME = 2 * SLOT;
  localparam int PER   = 2 * H;
  localparam int NFR   = 8;
`ifdef AUDIO_LOOPBACK_EN
  localparam sample_t FR4_WORD = 16'h8001;
`else
  localparam sample_t FR4_WORD = 16'h0F5A;
`endif

  logic    clk        = 1'b0;
  logic    reset_n    = 1'b0;
  sample_t sample_in  = '0;
  logic    loopback   = 1'b0;
  logic    aud_adcdat = 1'b0;
  logic    sample_req, sample_end, aud_bclk, aud_daclrck, aud_adclrck, aud_dacdat;
  sample_t sample_out;

  audio_codec_i2s #(
    .BCLK_HALF (H),
    .SLOT_BITS (SLOT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_in   (sample_in),
    .sample_req  (sample_req),
    .sample_out  (sample_out),
    .sample_end  (sample_end),
    .loopback    (loopback),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .aud_adclrck (aud_adclrck),
    .aud_dacdat  (aud_dacdat),
    .aud_adcdat  (aud_adcdat)
  );

  always #5 clk = ~clk;

  int      vectors     = 0;
  int      miscompares = 0;
  int      n           = 0;
  int      seg         = 0;
  logic    checking    = 1'b0;
  int      last_req    = -1;
  int      last_rise   = -1;
  logic    prev_bclk   = 1'b0;
  sample_t cap         = '0;

  sample_t tx_word    [NFR];
  sample_t adc_left   [NFR];
  logic    lb_frame   [NFR];
  sample_t load_val   [NFR];
  logic    load_fixed [NFR];

  logic    e_bclk, e_lrck, e_dat, e_req, e_end;
  sample_t e_out = '0;

  function automatic void chk1(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %b, want %b", name, n, act, exp);
    end
  endfunction

  function automatic void chk16(string name, sample_t act, sample_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, n, act, exp);
    end
  endfunction

  function automatic void chk_int(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, n, act, exp);
    end
  endfunction

  function automatic sample_t lit_dac(int fr);
    case (fr)
      1:       return 16'hA5C3;
      2:       return 16'h00FF;
      3:       return 16'hFF00;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic sample_t adc_expect(int fr);
`ifdef AUDIO_LOOPBACK_EN
    return lb_frame[fr] ? tx_word[fr] : adc_left[fr];
`else
    return adc_left[fr];
`endif
  endfunction

  // Expected outputs once m clk edges have elapsed since reset release.
  function automatic void model_after(int m);
    int f, b, p, fr, fs;
    f      = m / PER;
    e_bclk = ((m / H) % 2) == 1;
    e_dat  = 1'b0;
    e_lrck = 1'b0;
    if (f > 0) begin
      b      = (f - 1) % FRAME;
      fr     = (f - 1) / FRAME;
      p      = b % SLOT;
      e_lrck = (b >= SLOT);
      if (p >= 1 && p <= 16) e_dat = tx_word[fr][4'(16 - p)];
    end
    e_req = (m > 0) && (m % PER == 0) && (f % FRAME == 0);
    e_end = 1'b0;
    if (m > 1 && (m - 1) % PER == H) begin
      fs = (m - 1) / PER;
      if (fs >= 1 && (fs - 1) % FRAME == 16) begin
        e_end = 1'b1;
        e_out = adc_expect((fs - 1) / FRAME);
      end
    end
  endfunction

  // Inputs seen by clk edge m.
  function automatic void drive(int m);
    int   f, b, fr;
    logic adc;
    f  = m / PER;
    b  = (f == 0) ? FRAME - 1 : (f - 1) % FRAME;
    fr = (f == 0) ? 0 : (f - 1) / FRAME;
    if (m % PER == 0 && f >= 1 && b == 0 && fr >= 1) begin
      sample_in   = load_fixed[fr] ? load_val[fr] : 16'($urandom);
      tx_word[fr] = sample_in;
    end else if (seg == 0 && fr == 2) begin
      sample_in = 16'hFF00;
    end else begin
      sample_in = 16'($urandom);
    end
    adc = 1'($urandom);
    if (m % PER == H && f >= 1) begin
      if (b >= 1 && b <= 16)
        adc = adc_left[fr][4'(16 - b)];
      else if (b >= SLOT + 1 && b <= SLOT + 16)
        adc = (seg == 0 && fr == 1) ? 1'b1 : ~adc_left[fr][4'(SLOT + 16 - b)];
    end
    aud_adcdat = adc;
    loopback   = (f >= 1) ? lb_frame[fr] : 1'b0;
  endfunction

  function automatic void init_segment(int s);
    for (int i = 0; i < NFR; i++) begin
      adc_left[i]   = 16'($urandom);
      lb_frame[i]   = 1'($urandom);
      load_fixed[i] = 1'b0;
      load_val[i]   = '0;
      tx_word[i]    = '0;
    end
    if (s == 0) begin
      load_fixed[1] = 1'b1; load_val[1] = 16'hA5C3;
      load_fixed[2] = 1'b1; load_val[2] = 16'h00FF;
      load_fixed[3] = 1'b1; load_val[3] = 16'hFF00;
      load_fixed[4] = 1'b1; load_val[4] = 16'h8001;
      adc_left[1]   = 16'h1234; lb_frame[1] = 1'b0;
      adc_left[4]   = 16'h0F5A; lb_frame[4] = 1'b1;
    end
    e_out     = '0;
    last_req  = -1;
    last_rise = -1;
  endfunction

  function automatic int seg_len(int s);
    case (s)
      0:       return (5 * FRAME + 9) * PER + 2;
      1:       return (2 * FRAME + 17) * PER + H;
      default: return 5 * FRAME * PER + 16;
    endcase
  endfunction

  always @(negedge clk) begin
    int f, b, fr;
    if (checking) begin
      chk1("aud_bclk", aud_bclk, e_bclk);
      chk1("aud_daclrck", aud_daclrck, e_lrck);
      chk1("aud_adclrck", aud_adclrck, e_lrck);
      chk1("aud_dacdat", aud_dacdat, e_dat);
      chk1("sample_req", sample_req, e_req);
      chk1("sample_end", sample_end, e_end);
      chk16("sample_out", sample_out, e_out);

      if (aud_bclk && !prev_bclk) begin
        if (last_rise >= 0) chk_int("bclk_period", n - last_rise, 8);
        last_rise = n;
      end
      prev_bclk = aud_bclk;

      if (sample_req) begin
        if (last_req < 0) chk_int("first_req", n, 512);
        else              chk_int("req_spacing", n - last_req, 512);
        last_req = n;
      end

      if (n > 0 && n % PER == 0) begin
        f  = n / PER;
        b  = (f - 1) % FRAME;
        fr = (f - 1) / FRAME;
        if (b >= 1 && b <= 16) cap[4'(16 - b)] = aud_dacdat;
        if (b == 17 && seg == 0 && fr < 4) chk16("dac_word", cap, lit_dac(fr));
      end

      if (sample_end && seg == 0 && n >= 13) begin
        f  = (n - 5) / PER;
        fr = (f - 1) / FRAME;
        if (fr == 1) chk16("adc_word_1234", sample_out, 16'h1234);
        if (fr == 4) chk16("adc_word_f4", sample_out, FR4_WORD);
      end
    end
  end

  initial begin
    init_segment(0);
    model_after(0);
    checking = 1'b1;
    repeat (4) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      seg = s;
      init_segment(s);
      n = 0;
      model_after(0);
      drive(1);
      reset_n = 1'b1;
      repeat (seg_len(s)) begin
        @(posedge clk);
        #1;
        n++;
        model_after(n);
        drive(n + 1);
      end
      if (s < 2) begin
        #1;
        reset_n = 1'b0;
        n       = 0;
        e_out   = '0;
        model_after(0);
        #1;
        chk1("rst_bclk", aud_bclk, 1'b0);
        chk1("rst_lrck", aud_daclrck, 1'b0);
        chk1("rst_dacdat", aud_dacdat, 1'b0);
        chk1("rst_req", sample_req, 1'b0);
        chk1("rst_end", sample_end, 1'b0);
        chk16("rst_out", sample_out, 16'h0000);
        repeat (6) @(posedge clk);
      end
    end
    @(negedge clk);
    #1;
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
